// File: rtl/ewm_vec4_arb2.sv
// Two-requester arbiter in front of one shared ewm_vec4 multiplier.
// Burst-limited round-robin grant; an in-order tag FIFO steers results back.
module ewm_vec4_arb2 #(
    parameter int TILE_SIZE = 4,
    parameter int W         = 16,
    parameter int BURST     = 4,
    parameter int DEPTH     = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            r0_valid,
    output logic                            r0_ready,
    input  logic [W*TILE_SIZE-1:0]          r0_a_vec,
    input  logic [W*TILE_SIZE-1:0]          r0_b_vec,
    input  logic                            r1_valid,
    output logic                            r1_ready,
    input  logic [W*TILE_SIZE-1:0]          r1_a_vec,
    input  logic [W*TILE_SIZE-1:0]          r1_b_vec,
    output logic                            m_in_valid,
    input  logic                            m_in_ready,
    output logic [W*TILE_SIZE-1:0]          m_a_vec,
    output logic [W*TILE_SIZE-1:0]          m_b_vec,
    input  logic                            m_out_valid,
    output logic                            m_out_ready,
    input  logic [W*TILE_SIZE-1:0]          m_y_vec,
    output logic                            y0_valid,
    output logic                            y1_valid,
    input  logic                            y0_ready,
    input  logic                            y1_ready,
    output logic [W*TILE_SIZE-1:0]          y_vec,
    output logic [$clog2(DEPTH):0]          inflight,
    output logic                            err_orphan
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int CNTW = $clog2(BURST + 1);

    logic            cur;
    logic [CNTW-1:0] cnt;
    logic            tag_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic sel;
    logic sel_valid;
    logic v_cur;
    logic v_oth;
    logic tag_full;
    logic tag_empty;
    logic can_issue;
    logic fire;
    logic pop;
    logic head;

    // Owner keeps the grant until its burst is spent while the other side waits.
    always_comb begin
        v_cur = cur ? r1_valid : r0_valid;
        v_oth = cur ? r0_valid : r1_valid;
        sel   = cur;
        if (v_cur && ((cnt < CNTW'(BURST)) || !v_oth)) begin
            sel = cur;
        end else if (v_oth) begin
            sel = ~cur;
        end
    end

    assign sel_valid  = sel ? r1_valid : r0_valid;
    assign tag_full   = (count == CW'(DEPTH));
    assign tag_empty  = (count == '0);
    // rst_n gating keeps every handshake output low while reset is held.
    assign can_issue  = rst_n & ~tag_full;
    assign m_in_valid = sel_valid & can_issue;
    assign r0_ready   = ~sel & m_in_ready & can_issue;
    assign r1_ready   = sel & m_in_ready & can_issue;
    assign m_a_vec    = sel ? r1_a_vec : r0_a_vec;
    assign m_b_vec    = sel ? r1_b_vec : r0_b_vec;
    assign fire       = m_in_valid & m_in_ready;

    assign head        = tag_mem[rd_ptr];
    assign y0_valid    = m_out_valid & ~tag_empty & ~head;
    assign y1_valid    = m_out_valid & ~tag_empty & head;
    assign m_out_ready = ~tag_empty & (head ? y1_ready : y0_ready);
    assign pop         = m_out_valid & m_out_ready;
    assign y_vec       = m_y_vec;
    assign inflight    = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= 1'b0;
            cnt <= '0;
        end else if (fire) begin
            if (sel == cur) begin
                if (cnt < CNTW'(BURST)) begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cur <= sel;
                cnt <= CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (fire && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !fire) begin
                count <= count - 1'b1;
            end
            if (m_out_valid && tag_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: only slots between the pointers are read.
    always_ff @(posedge clk) begin
        if (fire) begin
            tag_mem[wr_ptr] <= sel;
        end
    end

endmodule

// File: tb/tb_ewm_vec4_arb2.sv
// Self-checking bench for ewm_vec4_arb2 with a Q8.8 multiplier model behind it
// and a queue-based reference of the grant and result-routing rules.
module tb_ewm_vec4_arb2;

    localparam int TILE  = 4;
    localparam int LW    = 16;
    localparam int VW    = TILE * LW;
    localparam int BURST = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          r0_valid, r0_ready, r1_valid, r1_ready;
    logic [VW-1:0] r0_a_vec, r0_b_vec, r1_a_vec, r1_b_vec;
    logic          m_in_valid, m_in_ready;
    logic [VW-1:0] m_a_vec, m_b_vec;
    logic          m_out_valid, m_out_ready;
    logic [VW-1:0] m_y_vec;
    logic          y0_valid, y1_valid, y0_ready, y1_ready;
    logic [VW-1:0] y_vec;
    logic [2:0]    inflight;
    logic          err_orphan;

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] mul_q [$];
    bit            inject;

    bit            own;
    int            run;
    bit            tagq [$];
    logic [VW-1:0] exp0 [$];
    logic [VW-1:0] exp1 [$];
    bit            orphan_exp;

    bit            acc0, acc1;
    int            dfires, dy0, dy1;
    bit            dut_log [$];
    logic [VW-1:0] last_y0, last_y1;

    always #5 clk = ~clk;

    ewm_vec4_arb2 #(.TILE_SIZE(TILE), .W(LW), .BURST(BURST), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a_vec(r0_a_vec), .r0_b_vec(r0_b_vec),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a_vec(r1_a_vec), .r1_b_vec(r1_b_vec),
        .m_in_valid(m_in_valid), .m_in_ready(m_in_ready),
        .m_a_vec(m_a_vec), .m_b_vec(m_b_vec),
        .m_out_valid(m_out_valid), .m_out_ready(m_out_ready), .m_y_vec(m_y_vec),
        .y0_valid(y0_valid), .y1_valid(y1_valid), .y0_ready(y0_ready), .y1_ready(y1_ready),
        .y_vec(y_vec), .inflight(inflight), .err_orphan(err_orphan)
    );

    // Signed Q8.8 lane-wise product, as the shared ewm_vec4 computes it.
    function automatic logic [VW-1:0] qmul(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0]      r;
        logic signed [31:0] p;
        r = '0;
        for (int i = 0; i < TILE; i++) begin
            p = $signed(a[LW*i +: LW]) * $signed(b[LW*i +: LW]);
            r[LW*i +: LW] = p[23:8];
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        return {$urandom, $urandom};
    endfunction

    // One clock: compare at the negedge against the reference, then advance
    // reference and multiplier model past the posedge.
    task automatic cycle();
        bit            oth, v_own, v_oth, sel, sel_v, full, mv;
        bit            e_r0r, e_r1r, e_miv, e_y0v, e_y1v, e_mor, mfire_e, pop_e;
        bit            d_fire, d_pop;
        logic [VW-1:0] d_prod, sel_a, sel_b;
        @(negedge clk);
        oth   = ~own;
        v_own = own ? r1_valid : r0_valid;
        v_oth = own ? r0_valid : r1_valid;
        if (v_own && (run < BURST || !v_oth)) sel = own;
        else if (v_oth) sel = oth;
        else sel = own;
        sel_v = sel ? r1_valid : r0_valid;
        sel_a = sel ? r1_a_vec : r0_a_vec;
        sel_b = sel ? r1_b_vec : r0_b_vec;
        full  = (tagq.size() == DEPTH);
        mv    = m_out_valid;
        e_r0r = rst_n && !full && m_in_ready && !sel;
        e_r1r = rst_n && !full && m_in_ready && sel;
        e_miv = rst_n && !full && sel_v;
        e_y0v = mv && tagq.size() > 0 && tagq[0] == 1'b0;
        e_y1v = mv && tagq.size() > 0 && tagq[0] == 1'b1;
        e_mor = tagq.size() > 0 && (tagq[0] ? y1_ready : y0_ready);

        checks++; if (r0_ready !== e_r0r) begin errors++; $display("[TB] FAIL r0_ready got %b want %b", r0_ready, e_r0r); end
        checks++; if (r1_ready !== e_r1r) begin errors++; $display("[TB] FAIL r1_ready got %b want %b", r1_ready, e_r1r); end
        checks++; if (m_in_valid !== e_miv) begin errors++; $display("[TB] FAIL m_in_valid got %b want %b", m_in_valid, e_miv); end
        checks++; if (y0_valid !== e_y0v) begin errors++; $display("[TB] FAIL y0_valid got %b want %b", y0_valid, e_y0v); end
        checks++; if (y1_valid !== e_y1v) begin errors++; $display("[TB] FAIL y1_valid got %b want %b", y1_valid, e_y1v); end
        checks++; if (m_out_ready !== e_mor) begin errors++; $display("[TB] FAIL m_out_ready got %b want %b", m_out_ready, e_mor); end
        checks++; if (inflight !== 3'(tagq.size())) begin errors++; $display("[TB] FAIL inflight got %0d want %0d", inflight, tagq.size()); end
        checks++; if (err_orphan !== orphan_exp) begin errors++; $display("[TB] FAIL err_orphan got %b want %b", err_orphan, orphan_exp); end
        if (e_miv) begin
            checks++;
            if (m_a_vec !== sel_a || m_b_vec !== sel_b) begin
                errors++; $display("[TB] FAIL operand_mux got a=%h b=%h want a=%h b=%h", m_a_vec, m_b_vec, sel_a, sel_b);
            end
        end
        if (e_y0v && y0_valid && exp0.size() > 0) begin
            checks++; if (y_vec !== exp0[0]) begin errors++; $display("[TB] FAIL y0_data got %h want %h", y_vec, exp0[0]); end
        end
        if (e_y1v && y1_valid && exp1.size() > 0) begin
            checks++; if (y_vec !== exp1[0]) begin errors++; $display("[TB] FAIL y1_data got %h want %h", y_vec, exp1[0]); end
        end

        mfire_e = e_miv && m_in_ready;
        pop_e   = mv && e_mor;
        d_fire  = m_in_valid && m_in_ready;
        d_prod  = qmul(m_a_vec, m_b_vec);
        d_pop   = m_out_valid && m_out_ready;
        acc0    = r0_valid && r0_ready;
        acc1    = r1_valid && r1_ready;
        if (acc0) begin dfires++; dut_log.push_back(1'b0); end
        if (acc1) begin dfires++; dut_log.push_back(1'b1); end
        if (y0_valid && y0_ready) begin dy0++; last_y0 = y_vec; end
        if (y1_valid && y1_ready) begin dy1++; last_y1 = y_vec; end

        @(posedge clk);
        #1;
        if (mv && tagq.size() == 0) orphan_exp = 1'b1;
        if (pop_e) begin
            if (tagq[0]) void'(exp1.pop_front());
            else void'(exp0.pop_front());
            void'(tagq.pop_front());
        end
        if (mfire_e) begin
            tagq.push_back(sel);
            if (sel) exp1.push_back(qmul(sel_a, sel_b));
            else exp0.push_back(qmul(sel_a, sel_b));
            if (sel == own) run = (run + 1 > BURST) ? BURST : run + 1;
            else begin own = sel; run = 1; end
        end
        if (d_pop && mul_q.size() > 0) void'(mul_q.pop_front());
        if (d_fire) mul_q.push_back(d_prod);
        m_out_valid = inject || (mul_q.size() > 0);
        m_y_vec     = (mul_q.size() > 0) ? mul_q[0] : rand_vec();
    endtask

    task automatic clear_state();
        mul_q.delete(); tagq.delete(); exp0.delete(); exp1.delete(); dut_log.delete();
        own = 1'b0; run = 0; orphan_exp = 1'b0; inject = 1'b0;
        acc0 = 1'b0; acc1 = 1'b0; dfires = 0; dy0 = 0; dy1 = 0;
        m_out_valid = 1'b0; m_y_vec = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        r0_valid = 1'b0; r1_valid = 1'b0;
        r0_a_vec = '0; r0_b_vec = '0; r1_a_vec = '0; r1_b_vec = '0;
        m_in_ready = 1'b1; y0_ready = 1'b1; y1_ready = 1'b1;
        clear_state();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        r0_valid = 1'b1; r1_valid = 1'b1;
        #1;
        checks++;
        if ({r0_ready, r1_ready, m_in_valid, m_out_ready, y0_valid, y1_valid, err_orphan} !== 7'b0 || inflight !== 3'd0) begin
            errors++; $display("[TB] FAIL reset_outputs got rdy=%b%b miv=%b mor=%b yv=%b%b inflight=%0d orphan=%b want all 0",
                r0_ready, r1_ready, m_in_valid, m_out_ready, y0_valid, y1_valid, inflight, err_orphan);
        end
        do_reset();
    endtask

    task automatic test_single_requester();
        int sent;
        do_reset();
        sent = 0;
        for (int c = 0; c < 40; c++) begin
            if (!r0_valid || acc0) begin
                r0_valid = (sent < 10);
                r0_a_vec = rand_vec(); r0_b_vec = rand_vec();
                if (r0_valid) sent++;
            end
            cycle();
        end
        checks++; if (dfires !== 10) begin errors++; $display("[TB] FAIL single_fires got %0d want 10", dfires); end
        checks++; if (dy0 !== 10 || dy1 !== 0) begin errors++; $display("[TB] FAIL single_results got y0=%0d y1=%0d want y0=10 y1=0", dy0, dy1); end
    endtask

    task automatic test_burst_round_robin();
        do_reset();
        r0_valid = 1'b1; r1_valid = 1'b1;
        for (int c = 0; c < 40 && dut_log.size() < 16; c++) begin
            r0_a_vec = rand_vec(); r0_b_vec = rand_vec();
            r1_a_vec = rand_vec(); r1_b_vec = rand_vec();
            cycle();
        end
        checks++;
        if (dut_log.size() < 16) begin
            errors++; $display("[TB] FAIL burst_timeout got %0d grants want 16", dut_log.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (dut_log[i] != bit'((i / BURST) % 2)) begin
                    errors++; $display("[TB] FAIL burst_pattern grant %0d got r%0d want r%0d", i, dut_log[i], (i / BURST) % 2);
                    break;
                end
            end
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        repeat (8) cycle();
    endtask

    task automatic test_stall_full();
        do_reset();
        y0_ready = 1'b0; y1_ready = 1'b0;
        r0_valid = 1'b1; r1_valid = 1'b1;
        repeat (10) cycle();
        checks++; if (dfires !== DEPTH) begin errors++; $display("[TB] FAIL stall_fires got %0d want %0d", dfires, DEPTH); end
        checks++;
        if (inflight !== 3'(DEPTH) || r0_ready !== 1'b0 || r1_ready !== 1'b0 || m_in_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL stall_full got inflight=%0d rdy=%b%b miv=%b want 4 00 0", inflight, r0_ready, r1_ready, m_in_valid);
        end
        y0_ready = 1'b1; y1_ready = 1'b1;
        repeat (12) cycle();
        checks++; if (dfires <= DEPTH) begin errors++; $display("[TB] FAIL stall_resume got %0d fires want more than %0d", dfires, DEPTH); end
        r0_valid = 1'b0; r1_valid = 1'b0;
        repeat (8) cycle();
    endtask

    task automatic test_q88_routing();
        do_reset();
        r0_a_vec = {4{16'h0100}}; r0_b_vec = {4{16'h0200}};
        r1_a_vec = {4{16'hFF00}}; r1_b_vec = {4{16'h0300}};
        r0_valid = 1'b1; r1_valid = 1'b1;
        last_y0 = '0; last_y1 = '0;
        repeat (14) cycle();
        r0_valid = 1'b0; r1_valid = 1'b0;
        repeat (6) cycle();
        checks++; if (last_y0 !== {4{16'h0200}} || dy0 == 0) begin errors++; $display("[TB] FAIL q88_y0 got %h (n=%0d) want %h", last_y0, dy0, {4{16'h0200}}); end
        checks++; if (last_y1 !== {4{16'hFD00}} || dy1 == 0) begin errors++; $display("[TB] FAIL q88_y1 got %h (n=%0d) want %h", last_y1, dy1, {4{16'hFD00}}); end
    endtask

    task automatic test_orphan();
        do_reset();
        inject = 1'b1;
        m_out_valid = 1'b1;
        m_y_vec = rand_vec();
        cycle();
        inject = 1'b0;
        m_out_valid = 1'b0;
        repeat (3) cycle();
        checks++; if (err_orphan !== 1'b1) begin errors++; $display("[TB] FAIL orphan_sticky got %b want 1", err_orphan); end
        rst_n = 1'b0;
        #1;
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("[TB] FAIL orphan_reset got %b want 0", err_orphan); end
        do_reset();
    endtask

    task automatic test_reset_midop();
        do_reset();
        y0_ready = 1'b0; y1_ready = 1'b0;
        r0_valid = 1'b1;
        for (int c = 0; c < 20 && tagq.size() < 3; c++) cycle();
        r0_valid = 1'b0;
        checks++; if (inflight !== 3'd3) begin errors++; $display("[TB] FAIL midop_fill got %0d want 3", inflight); end
        r0_valid = 1'b1; r1_valid = 1'b1; y0_ready = 1'b1; y1_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({r0_ready, r1_ready, m_in_valid, m_out_ready, y0_valid, y1_valid, err_orphan} !== 7'b0 || inflight !== 3'd0) begin
            errors++; $display("[TB] FAIL midop_async got rdy=%b%b miv=%b mor=%b yv=%b%b inflight=%0d want all 0",
                r0_ready, r1_ready, m_in_valid, m_out_ready, y0_valid, y1_valid, inflight);
        end
        clear_state();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (inflight !== 3'd0 || r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL midop_release got inflight=%0d rdy=%b%b want 0 10", inflight, r0_ready, r1_ready);
        end
        @(posedge clk);
        #1;
        clear_state();
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (!r0_valid || acc0) begin
                r0_valid = ($urandom_range(0, 3) != 0);
                r0_a_vec = rand_vec(); r0_b_vec = rand_vec();
            end
            if (!r1_valid || acc1) begin
                r1_valid = ($urandom_range(0, 3) != 0);
                r1_a_vec = rand_vec(); r1_b_vec = rand_vec();
            end
            m_in_ready = ($urandom_range(0, 4) != 0);
            y0_ready   = ($urandom_range(0, 2) != 0);
            y1_ready   = ($urandom_range(0, 2) != 0);
            cycle();
        end
        checks++; if (dy0 == 0 || dy1 == 0) begin errors++; $display("[TB] FAIL random_traffic got y0=%0d y1=%0d want both nonzero", dy0, dy1); end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_state();
        test_reset();
        test_single_requester();
        test_burst_round_robin();
        test_stall_full();
        test_q88_routing();
        test_orphan();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ewm_vec4_arb2.md
Name: ewm_vec4_arb2

Overview:
Two-requester arbiter that shares one ewm_vec4 element-wise multiplier between two vector streams. Typical users are the output-gate path (s ⊙ g) and the EW state-update path. Operand pairs are granted with burst-limited round-robin and forwarded to the shared multiplier. Each accepted beat's requester ID goes into an in-order tag FIFO, which routes every multiplier result back to the requester that issued it.

Parameters:
TILE_SIZE, 4, lanes per vector beat
W, 16, lane width (bits)
BURST, 4, max consecutive beats granted to one requester while the other is waiting (≥1)
DEPTH, 4, tag FIFO depth = max beats in flight inside the multiplier (power of 2, ≥2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
r0_valid  in  1  requester 0 operand pair valid
r0_ready  out  1  requester 0 accepted
r0_a_vec  in  W x TILE_SIZE  requester 0 operand A
r0_b_vec  in  W x TILE_SIZE  requester 0 operand B
r1_valid / r1_ready / r1_a_vec / r1_b_vec  same as above, for requester 1
m_in_valid  out  1  to multiplier in_valid
m_in_ready  in  1  from multiplier in_ready
m_a_vec, m_b_vec  out  W x TILE_SIZE  operands muxed from the granted requester
m_out_valid  in  1  multiplier result valid
m_out_ready  out  1  to multiplier out_ready
m_y_vec  in  W x TILE_SIZE  multiplier result
y0_valid / y1_valid  out  1  result valid for requester 0 / 1
y0_ready / y1_ready  in  1  result ready from requester 0 / 1
y_vec  out  W x TILE_SIZE  m_y_vec passthrough (shared by both result ports)
inflight  out  $clog2(DEPTH)+1  tag FIFO occupancy
err_orphan  out  1  sticky: multiplier produced a result with no tag outstanding

Behaviour:
- Registered state: cur (owner, reset 0), cnt (0..BURST, reset 0), tag FIFO (wr_ptr, rd_ptr, count, reset empty), err_orphan (reset 0).
- Output values while rst_n=0: r*_ready=0, m_in_valid=0, m_out_ready=0, y*_valid=0, inflight=0, err_orphan=0.
- Grant select (combinational), with oth = ~cur:
  - sel = cur if r_cur_valid && (cnt<BURST || !r_oth_valid)
  - else sel = oth if r_oth_valid
  - else sel = cur
- can_issue = !tag_full. A pop in the same cycle does not free a slot for a push; the full check is conservative.
- m_in_valid = r_sel_valid & can_issue. m_a_vec/m_b_vec are muxed from sel.
- r_sel_ready = m_in_ready & can_issue. The non-selected requester's ready is 0.
- No valid→ready combinational loop: ready does not depend on the requester's own valid beyond sel.
- fire = m_in_valid & m_in_ready. On fire:
  - push sel into the tag FIFO.
  - if sel==cur: cnt <= min(cnt+1, BURST).
  - else: cur <= sel, cnt <= 1.
- No fire → cur and cnt hold.
- Result routing, with head = FIFO head tag:
  - y0_valid = m_out_valid & !empty & head==0.
  - y1_valid = m_out_valid & !empty & head==1.
  - m_out_ready = !empty & (head ? y1_ready : y0_ready).
  - Pop on m_out_valid & m_out_ready.
- Results return in issue order; the arbiter adds zero latency on both paths.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Wrap-around: pointers are modulo DEPTH.
- Full (count==DEPTH): both requester readies are 0 and m_in_valid=0 until a pop has registered.
- err_orphan: set when m_out_valid & empty. It is sticky until reset, and that result is not consumed (m_out_ready=0).
- inflight = count.
- Reset mid-operation clears all tags. The multiplier must be reset on the same rst_n.

Test Plan:
1. Only r0 valid for 10 beats, m_in_ready=1, multiplier latency 1 → 10 fires, all tags 0, y0 receives 10 results in order, y1_valid never 1.
2. Both requesters valid continuously, BURST=4 → grant pattern r0×4, r1×4, r0×4…; y0 and y1 results appear in the same grouping.
3. m_out_ready path stalled (y0_ready=y1_ready=0) with DEPTH=4 → exactly 4 fires, then r*_ready=0 and inflight=4; release y0_ready/y1_ready → drains in order, issue resumes.
4. r0 sends a=0x0100 (1.0 Q8.8), b=0x0200 (2.0); r1 sends a=0xFF00 (-1.0), b=0x0300 (3.0), interleaved → y0=0x0200, y1=0xFD00, each on the correct port.
5. Inject m_out_valid with an empty FIFO → err_orphan=1, m_out_ready=0; err_orphan stays 1 until rst_n is asserted.
6. Assert rst_n=0 with inflight=3 → all outputs 0 immediately (asynchronously); after release, inflight=0 and cur=0.
